// File: rtl/spirx_burst_ctrl.sv
// spirx_burst_ctrl: frames SPI receive words into bursts and buffers the payload in a ring.
// Bursts are committed atomically; an oversized header flushes unread data (self-freshen).
// Optional build macro: SPIRX_BURST_CHECKSUM_EN adds a trailing checksum word per burst.
module spirx_burst_ctrl #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned TIMEOUT    = 1024,
  parameter logic [3:0]  SYNC       = 4'hA
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           word_in,
  input  logic                  word_stb,
  output logic [15:0]           dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  busy,
  output logic                  burst_done,
  output logic                  burst_err,
  output logic                  overflow,
  input  logic                  clr,
  output logic [7:0]            hdr_err_cnt
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2 + 1;
  localparam int unsigned TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TmrMax = TW'(TIMEOUT - 1);
  localparam logic [PW-1:0] DepthP = PW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StPayload, StCheck} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   wr_commit_q, wr_commit_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   rem_q, rem_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      herr_q, herr_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
`ifdef SPIRX_BURST_CHECKSUM_EN
  logic [15:0]     csum_q, csum_d;
`endif

  logic [15:0]     mem_q [DEPTH];
  logic            mem_we;
  logic [PW-1:0]   level_w, free_w;
  logic [7:0]      hdr_len;
  logic            hdr_ok, pop;
  logic            unused_hdr_bits;

  assign level_w         = wr_commit_q - rd_ptr_q;
  assign free_w          = DepthP - level_w;
  assign hdr_len         = word_in[7:0];
  assign hdr_ok          = (word_in[15:12] == SYNC) && (hdr_len != 8'd0) &&
                           ({1'b0, hdr_len} <= 9'(DEPTH));
  assign pop             = dout_valid && dout_ready;
  assign unused_hdr_bits = ^word_in[11:8];

  // Next-state: burst sequencing, commit/abort, flush, pops and status counters
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    rd_ptr_d    = rd_ptr_q;
    rem_d       = rem_q;
    tmr_d       = tmr_q;
    ovf_d       = ovf_q;
    herr_d      = herr_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    mem_we      = 1'b0;
`ifdef SPIRX_BURST_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (clr) begin
      ovf_d  = 1'b0;
      herr_d = 8'd0;
    end

    unique case (state_q)
      StIdle: begin
        if (word_stb) begin
          if (hdr_ok) begin
            rem_d   = PW'(hdr_len);
            tmr_d   = '0;
            state_d = StPayload;
`ifdef SPIRX_BURST_CHECKSUM_EN
            csum_d  = word_in;
`endif
            // Not enough room: drop unread data so the consumer sees only fresh bursts.
            // Overrides any same-cycle pop, and the set beats clr.
            if ({1'b0, hdr_len} > 9'(free_w)) begin
              rd_ptr_d = wr_commit_q;
              ovf_d    = 1'b1;
            end
          end else if (!clr && (herr_q != 8'hFF)) begin
            herr_d = herr_q + 8'd1;
          end
        end
      end
      StPayload: begin
        if (word_stb) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PW'(1);
          rem_d    = rem_q - PW'(1);
          tmr_d    = '0;
`ifdef SPIRX_BURST_CHECKSUM_EN
          csum_d   = csum_q + word_in;
          if (rem_q == PW'(1)) state_d = StCheck;
`else
          if (rem_q == PW'(1)) begin
            wr_commit_d = wr_ptr_q + PW'(1);
            done_d      = 1'b1;
            state_d     = StIdle;
          end
`endif
        end else if (tmr_q == TmrMax) begin
          wr_ptr_d = wr_commit_q;
          err_d    = 1'b1;
          state_d  = StIdle;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
`ifdef SPIRX_BURST_CHECKSUM_EN
      StCheck: begin
        if (word_stb) begin
          state_d = StIdle;
          if (word_in == csum_q) begin
            wr_commit_d = wr_ptr_q;
            done_d      = 1'b1;
          end else begin
            wr_ptr_d = wr_commit_q;
            err_d    = 1'b1;
          end
        end else if (tmr_q == TmrMax) begin
          wr_ptr_d = wr_commit_q;
          err_d    = 1'b1;
          state_d  = StIdle;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; reset discards committed data too
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      rem_q       <= '0;
      tmr_q       <= '0;
      ovf_q       <= 1'b0;
      herr_q      <= 8'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef SPIRX_BURST_CHECKSUM_EN
      csum_q      <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
      rem_q       <= rem_d;
      tmr_q       <= tmr_d;
      ovf_q       <= ovf_d;
      herr_q      <= herr_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef SPIRX_BURST_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  // Payload storage; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= word_in;
  end

  assign dout        = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign dout_valid  = (level_w != '0);
  assign level       = level_w;
  assign busy        = (state_q != StIdle);
  assign burst_done  = done_q;
  assign burst_err   = err_q;
  assign overflow    = ovf_q;
  assign hdr_err_cnt = herr_q;

endmodule

// File: tb/tb_spirx_burst_ctrl.sv
// Self-checking bench for spirx_burst_ctrl: header table, scoreboard of committed words,
// hand sequences for self-freshen, timeout, checksum (when built in), concurrency and reset.
module tb_spirx_burst_ctrl;

  localparam int unsigned DEPTH_LOG2 = 4;
  localparam int unsigned DEPTH      = 16;
  localparam int unsigned TIMEOUT    = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] word_in = 16'd0;
  logic        word_stb = 1'b0;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic [DEPTH_LOG2:0] level;
  logic        busy, burst_done, burst_err, overflow;
  logic        clr = 1'b0;
  logic [7:0]  hdr_err_cnt;

  spirx_burst_ctrl #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .TIMEOUT    (TIMEOUT),
    .SYNC       (4'hA)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .word_in     (word_in),
    .word_stb    (word_stb),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .level       (level),
    .busy        (busy),
    .burst_done  (burst_done),
    .burst_err   (burst_err),
    .overflow    (overflow),
    .clr         (clr),
    .hdr_err_cnt (hdr_err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q [$];
  logic [15:0] pend_q [$];

  typedef struct {
    logic [15:0] hdr;
    logic        accept;
  } hdr_vec_t;
  hdr_vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, scoreboard any pop, return at the next negedge
  task automatic cycle(input logic stb, input logic [15:0] w, input logic rdy,
                       input logic commit);
    logic [15:0] head;
    word_stb   = stb;
    word_in    = w;
    dout_ready = rdy;
    if (rdy && dout_valid) begin
      if (exp_q.size() == 0) check("pop_extra_valid", dout_valid, 1'b0);
      else begin
        head = exp_q.pop_front();
        check("dout", dout, head);
      end
    end
    if (commit) while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
    @(negedge clk);
    word_stb   = 1'b0;
    dout_ready = 1'b0;
  endtask

  task automatic send_payload(input logic [15:0] hdr, input int n, input logic [15:0] base,
                              input logic [15:0] step, input logic rdy);
    logic [15:0] sum;
    logic [15:0] w;
    sum = hdr;
    for (int k = 0; k < n; k++) begin
      w = base + 16'(k) * step;
      pend_q.push_back(w);
      sum = sum + w;
`ifdef SPIRX_BURST_CHECKSUM_EN
      cycle(1'b1, w, rdy, 1'b0);
`else
      cycle(1'b1, w, rdy, k == n - 1);
`endif
    end
`ifdef SPIRX_BURST_CHECKSUM_EN
    cycle(1'b1, sum, rdy, 1'b1);
`endif
  endtask

  task automatic send_burst(input logic [15:0] hdr, input int n, input logic [15:0] base,
                            input logic [15:0] step, input logic rdy);
    cycle(1'b1, hdr, rdy, 1'b0);
    send_payload(hdr, n, base, step, rdy);
  endtask

  task automatic drain(input string name);
    int guard = 0;
    while (exp_q.size() > 0 && guard < 4 * DEPTH) begin
      cycle(1'b0, 16'd0, 1'b1, 1'b0);
      guard++;
    end
    check({name, "_left"}, exp_q.size(), 0);
    check({name, "_valid"}, dout_valid, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int herr_exp;
    int n;
    int lvl;
    vecs[0] = '{16'h5003, 1'b0};
    vecs[1] = '{16'hA000, 1'b0};
    vecs[2] = '{16'hA011, 1'b0};
    vecs[3] = '{16'hA002, 1'b1};
    vecs[4] = '{16'hB001, 1'b0};
    vecs[5] = '{16'hAF10, 1'b1};
    vecs[6] = '{16'hA111, 1'b0};
    vecs[7] = '{16'hA501, 1'b1};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_level", level, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", burst_done, 0);
    check("rst_err", burst_err, 0);
    check("rst_ovf", overflow, 0);
    check("rst_herr", hdr_err_cnt, 0);

    // Basic burst
    send_burst(16'hA003, 3, 16'h0011, 16'h0011, 1'b0);
    check("basic_done", burst_done, 1);
    check("basic_level", level, 3);
    check("basic_valid", dout_valid, 1);
    cycle(1'b0, 16'd0, 1'b0, 1'b0);
    check("basic_done_pulse", burst_done, 0);
    drain("basic_drain");

    // Header classification table
    herr_exp = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, vecs[i].hdr, 1'b0, 1'b0);
      if (!vecs[i].accept) herr_exp++;
      check($sformatf("hdr%0d_busy", i), busy, vecs[i].accept);
      check($sformatf("hdr%0d_cnt", i), hdr_err_cnt, herr_exp);
      if (vecs[i].accept) begin
        send_payload(vecs[i].hdr, int'(vecs[i].hdr[7:0]), 16'h1000 + 16'(i) * 16'h0100,
                     16'd1, 1'b0);
        check($sformatf("hdr%0d_done", i), burst_done, 1);
        check($sformatf("hdr%0d_level", i), level, vecs[i].hdr[7:0]);
        drain($sformatf("hdr%0d_drain", i));
      end
    end

    // Self-freshen: 12 unread, then an 8-word header flushes (same-cycle pop ignored)
    send_burst(16'hA00C, 12, 16'h0100, 16'd1, 1'b0);
    check("fresh_pre_level", level, 12);
    cycle(1'b1, 16'hA008, 1'b1, 1'b0);
    exp_q.delete();
    check("fresh_level0", level, 0);
    check("fresh_ovf", overflow, 1);
    check("fresh_valid0", dout_valid, 0);
    check("fresh_busy", busy, 1);
    send_payload(16'hA008, 8, 16'h0200, 16'd1, 1'b0);
    check("fresh_level8", level, 8);
    check("fresh_head", dout, 16'h0200);
    drain("fresh_drain");
    check("fresh_ovf_sticky", overflow, 1);
    clr = 1'b1;
    cycle(1'b0, 16'd0, 1'b0, 1'b0);
    clr = 1'b0;
    check("clr_ovf", overflow, 0);
    check("clr_herr", hdr_err_cnt, 0);

    // Timeout mid-burst
    send_burst(16'hA002, 2, 16'h0300, 16'd1, 1'b0);
    cycle(1'b1, 16'hA004, 1'b0, 1'b0);
    cycle(1'b1, 16'h0400, 1'b0, 1'b0);
    cycle(1'b1, 16'h0401, 1'b0, 1'b0);
    check("to_busy", busy, 1);
    n = 0;
    while (!burst_err && n < int'(TIMEOUT) + 8) begin
      cycle(1'b0, 16'd0, 1'b0, 1'b0);
      n++;
    end
    check("to_cycles", n, TIMEOUT);
    check("to_level", level, 2);
    check("to_busy_after", busy, 0);
    cycle(1'b0, 16'd0, 1'b0, 1'b0);
    check("to_err_pulse", burst_err, 0);
    send_burst(16'hA001, 1, 16'h00FF, 16'd0, 1'b0);
    check("to_next_level", level, 3);
    drain("to_drain");

`ifdef SPIRX_BURST_CHECKSUM_EN
    // Checksum match then mismatch
    send_burst(16'hA003, 3, 16'h0001, 16'd1, 1'b0);
    check("cs_done", burst_done, 1);
    check("cs_level", level, 3);
    cycle(1'b1, 16'hA003, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) cycle(1'b1, 16'(k), 1'b0, 1'b0);
    cycle(1'b1, 16'hA008, 1'b0, 1'b0);
    check("cs_bad_err", burst_err, 1);
    check("cs_bad_done", burst_done, 0);
    check("cs_bad_level", level, 3);
    drain("cs_drain");
`endif

    // Concurrency: pop every cycle while bursts commit, then flush and reset mid-payload
    send_burst(16'hA004, 4, 16'h0500, 16'd1, 1'b0);
    send_burst(16'hA005, 5, 16'h0600, 16'd1, 1'b1);
    check("cc_done", burst_done, 1);
    lvl = exp_q.size();
    check("cc_level", level, lvl);
    cycle(1'b1, 16'h5123, 1'b1, 1'b0);
    check("cc_herr", hdr_err_cnt, 1);
    drain("cc_drain");
    send_burst(16'hA00A, 10, 16'h0700, 16'd1, 1'b0);
    cycle(1'b1, 16'hA008, 1'b1, 1'b0);
    exp_q.delete();
    check("cc_flush_level", level, 0);
    check("cc_flush_ovf", overflow, 1);
    cycle(1'b1, 16'h0800, 1'b1, 1'b0);
    cycle(1'b1, 16'h0801, 1'b1, 1'b0);
    reset = 1'b1;
    cycle(1'b0, 16'd0, 1'b0, 1'b0);
    reset = 1'b0;
    pend_q.delete();
    check("rst2_level", level, 0);
    check("rst2_valid", dout_valid, 0);
    check("rst2_busy", busy, 0);
    check("rst2_done", burst_done, 0);
    check("rst2_err", burst_err, 0);
    check("rst2_ovf", overflow, 0);
    check("rst2_herr", hdr_err_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
